// File: rtl/dds_pkg.sv
// Shared types and default widths for the DDS sweep controller.
// No logic; no latency.
// No flow control here; see dds_sweep_ctrl for the handshake rules.
package dds_pkg;

    localparam int FTW_W   = 16;
    localparam int DWELL_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        STEP  = 2'd2
    } sweep_state_t;

    typedef struct packed {
        logic [FTW_W-1:0]   start;
        logic [FTW_W-1:0]   stop;
        logic [FTW_W-1:0]   step;
        logic [DWELL_W-1:0] dwell;
        logic               rpt;
    } sweep_cfg_t;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Config handshake, sweep control and FTW output bundle for the sweep controller.
// No logic; no latency.
// cfg_valid/cfg_ready handshake; the remaining signals are pulses or levels.
interface dds_sweep_ctrl_if #(
    parameter int FTW_W   = dds_pkg::FTW_W,
    parameter int DWELL_W = dds_pkg::DWELL_W
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [FTW_W-1:0]   cfg_start;
    logic [FTW_W-1:0]   cfg_stop;
    logic [FTW_W-1:0]   cfg_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               cfg_repeat;
    logic               start;
    logic               abort;
    logic [FTW_W-1:0]   ftw;
    logic               ftw_upd;
    logic               busy;
    logic               done;

    modport master (
        output cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_repeat,
        output start, abort,
        input  cfg_ready, ftw, ftw_upd, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_repeat,
        input  start, abort,
        output cfg_ready, ftw, ftw_upd, busy, done
    );
endinterface

// File: rtl/dds_dwell_cnt.sv
// Loadable down-counter with zero flag, used to time the dwell on each FTW.
// Load/decrement take effect on the next clk; zero flag is a decode of the register.
// No backpressure; load has priority over decrement.
module dds_dwell_cnt
    import dds_pkg::*;
#(
    parameter int W = DWELL_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear FTW sweep sequencer (start->stop in fixed steps, dwell per step) feeding a DDS accumulator.
// Outputs registered: first FTW one clk after start; per-step period dwell+2 clk.
// cfg_ready only in IDLE, so config is frozen for a whole sweep; start while busy is dropped.
module dds_sweep_ctrl #(
    parameter int FTW_W   = dds_pkg::FTW_W,
    parameter int DWELL_W = dds_pkg::DWELL_W
) (
    input  logic            clk,
    input  logic            rstn,
    dds_sweep_ctrl_if.slave bus
);
    import dds_pkg::*;

    sweep_state_t     state, state_d;
    sweep_cfg_t       cfg_l, cfg_in, cfg_eff;
    logic             cfg_acc;

    logic [FTW_W-1:0] ftw_q, ftw_d;
    logic             upd_q, upd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic               cnt_load, cnt_dec, cnt_zero;
    logic [DWELL_W-1:0] cnt_val;

    logic             down;
    logic [FTW_W:0]   sum, diff;
    logic             past_stop;
    logic [FTW_W-1:0] nxt;
    logic             final_pt;

    assign bus.cfg_ready = (state == IDLE);
    assign cfg_acc       = bus.cfg_valid && (state == IDLE);

    always_comb begin
        cfg_in.start = bus.cfg_start;
        cfg_in.stop  = bus.cfg_stop;
        cfg_in.step  = bus.cfg_step;
        cfg_in.dwell = bus.cfg_dwell;
        cfg_in.rpt   = bus.cfg_repeat;
    end

    // A start in the same cycle as a config accept must see the new config.
    assign cfg_eff = cfg_acc ? cfg_in : cfg_l;

    // Extra MSB catches carry (up) or borrow (down) so the sweep saturates at stop, never wraps.
    assign down      = (cfg_l.start > cfg_l.stop);
    assign sum       = {1'b0, ftw_q} + {1'b0, cfg_l.step};
    assign diff      = {1'b0, ftw_q} - {1'b0, cfg_l.step};
    assign past_stop = down ? (diff[FTW_W] || (diff[FTW_W-1:0] < cfg_l.stop))
                            : (sum[FTW_W]  || (sum[FTW_W-1:0]  > cfg_l.stop));
    assign nxt       = past_stop ? cfg_l.stop : (down ? diff[FTW_W-1:0] : sum[FTW_W-1:0]);
    assign final_pt  = (ftw_q == cfg_l.stop) || (cfg_l.step == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        ftw_d    = ftw_q;
        upd_d    = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = cfg_l.dwell;
        if (bus.abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_d  = DWELL;
                        ftw_d    = cfg_eff.start;
                        upd_d    = 1'b1;
                        busy_d   = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = cfg_eff.dwell;
                    end
                end
                DWELL: begin
                    if (cnt_zero) begin
                        state_d = STEP;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                STEP: begin
                    if (final_pt && !cfg_l.rpt) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = DWELL;
                        ftw_d    = final_pt ? cfg_l.start : nxt;
                        upd_d    = 1'b1;
                        cnt_load = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ftw_q  <= '0;
            upd_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cfg_l  <= '0;
        end else begin
            ftw_q  <= ftw_d;
            upd_q  <= upd_d;
            busy_q <= busy_d;
            done_q <= done_d;
            if (cfg_acc) begin
                cfg_l <= cfg_in;
            end
        end
    end

    dds_dwell_cnt #(.W(DWELL_W)) u_dwell_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    assign bus.ftw     = ftw_q;
    assign bus.ftw_upd = upd_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule
